// File: rtl/extrema_window_reader_pkg.sv
// Shared constants and types for the extremum window reader.
package extrema_window_reader_pkg;

  // Default sample/position width and window output width.
  localparam int unsigned EWR_DW = 16;
  localparam int unsigned EWR_OW = 20;

  // One extremum as pushed by the detector.
  typedef struct packed {
    logic [EWR_DW-1:0] value;     // signed two's complement
    logic [EWR_DW-1:0] position;  // raw sample counter
  } ext_pair_t;

  // Window state: FILL while fewer than three points are stored.
  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_VALID = 1'b1
  } win_state_e;

endpackage : extrema_window_reader_pkg

// File: rtl/extrema_ring.sv
// Ring buffer of (value, position) pairs with three read taps at the
// post-update read pointer. A tap that lands on the slot being written this
// cycle returns the incoming pair, so the window can load on the same edge.
module extrema_ring
  import extrema_window_reader_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = EWR_DW
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [DW-1:0]        wr_val_i,
  input  logic [DW-1:0]        wr_time_i,
  output logic [AW:0]          level_o,
  output logic [AW:0]          level_next_o,
  output logic                 full_o,
  output logic                 push_ok_o,
  output logic [2:0][DW-1:0]   tap_val_o,
  output logic [2:0][DW-1:0]   tap_time_o
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [DW-1:0] val_q  [DEPTH];
  logic [DW-1:0] time_q [DEPTH];
  logic          full;
  logic          push_ok;

  assign full    = (level_q == FULL_LEVEL);
  // A push into a full ring is still accepted when a pop frees a slot.
  assign push_ok = push_i & (~full | pop_i);

  // Next pointers and fill level.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)   rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_i})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer, level and storage registers; clear wipes stored data too.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        val_q[i]  <= '0;
        time_q[i] <= '0;
      end
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        val_q[i]  <= '0;
        time_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (push_ok) begin
        val_q[wr_ptr_q]  <= wr_val_i;
        time_q[wr_ptr_q] <= wr_time_i;
      end
    end
  end

  // Read taps at rd_ptr_d + 0/1/2 with bypass of the pair written this cycle.
  for (genvar gi = 0; gi < 3; gi++) begin : g_tap
    logic [AW-1:0] addr;
    logic          hit;
    assign addr = rd_ptr_d + AW'(gi);
    assign hit  = push_ok && (addr == wr_ptr_q);
    assign tap_val_o[gi]  = hit ? wr_val_i  : val_q[addr];
    assign tap_time_o[gi] = hit ? wr_time_i : time_q[addr];
  end

  assign level_o      = level_q;
  assign level_next_o = level_d;
  assign full_o       = full;
  assign push_ok_o    = push_ok;

endmodule : extrema_ring

// File: rtl/extrema_window_reader.sv
// Sliding 3-point extremum window for the spline interpolator. Extrema are
// buffered in a ring; each segment-done pulse drops the oldest point.
module extrema_window_reader
  import extrema_window_reader_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = EWR_DW,
  parameter int OW    = EWR_OW
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          start,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_val,
  input  logic [DW-1:0] wr_time,
  input  logic          adv,
  output logic          win_valid,
  output logic [OW-1:0] M1,
  output logic [OW-1:0] M2,
  output logic [OW-1:0] M3,
  output logic [OW-1:0] P1,
  output logic [OW-1:0] P2,
  output logic [OW-1:0] P3,
  output logic [4:0]    win_idx,
  output logic [AW:0]   level,
  output logic          full,
  output logic          overflow
);

  localparam logic [AW:0] MIN_WINDOW = (AW+1)'(3);

  win_state_e          state_q, state_d;
  logic [4:0]          win_idx_q, win_idx_d;
  logic                overflow_q, overflow_d;
  logic                pop;
  logic                load;
  logic                push_ok;
  logic [AW:0]         level_next;
  logic [2:0][DW-1:0]  tap_val;
  logic [2:0][DW-1:0]  tap_time;

  // A pop is only meaningful while a window is being presented.
  assign pop = adv & (state_q == ST_VALID);

  extrema_ring #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_ring (
    .clk_i        (CLK),
    .rst_ni       (RSTn),
    .clr_i        (start),
    .push_i       (wr_en),
    .pop_i        (pop),
    .wr_val_i     (wr_val),
    .wr_time_i    (wr_time),
    .level_o      (level),
    .level_next_o (level_next),
    .full_o       (full),
    .push_ok_o    (push_ok),
    .tap_val_o    (tap_val),
    .tap_time_o   (tap_time)
  );

  // Window FSM next state, window reload strobe, counters.
  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    win_idx_d  = win_idx_q;
    overflow_d = overflow_q | (wr_en & ~push_ok);
    case (state_q)
      ST_FILL: begin
        if (level_next >= MIN_WINDOW) begin
          state_d = ST_VALID;
          load    = 1'b1;
        end
      end
      ST_VALID: begin
        if (pop) begin
          win_idx_d = win_idx_q + 5'd1;
          if (level_next >= MIN_WINDOW) load = 1'b1;
          else                          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // State, segment counter and sticky overflow; start beats push/pop.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= ST_FILL;
      win_idx_q  <= '0;
      overflow_q <= 1'b0;
    end else if (start) begin
      state_q    <= ST_FILL;
      win_idx_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_idx_q  <= win_idx_d;
      overflow_q <= overflow_d;
    end
  end

  // Window registers, one (M, P) pair per tap, held between reloads.
  for (genvar gi = 0; gi < 3; gi++) begin : g_win
    logic [OW-1:0] m_q;
    logic [OW-1:0] p_q;

    // Load sign-extended value and zero-extended position on reload.
    always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
        m_q <= '0;
        p_q <= '0;
      end else if (start) begin
        m_q <= '0;
        p_q <= '0;
      end else if (load) begin
        m_q <= {{(OW-DW){tap_val[gi][DW-1]}}, tap_val[gi]};
        p_q <= {{(OW-DW){1'b0}}, tap_time[gi]};
      end
    end
  end

  assign M1        = g_win[0].m_q;
  assign M2        = g_win[1].m_q;
  assign M3        = g_win[2].m_q;
  assign P1        = g_win[0].p_q;
  assign P2        = g_win[1].p_q;
  assign P3        = g_win[2].p_q;
  assign win_valid = (state_q == ST_VALID);
  assign win_idx   = win_idx_q;
  assign overflow  = overflow_q;

endmodule : extrema_window_reader

// File: tb/tb_extrema_window_reader.sv
// Directed table-driven bench for extrema_window_reader.
module tb_extrema_window_reader;
  import extrema_window_reader_pkg::*;

  logic        CLK;
  logic        RSTn;
  logic        start;
  logic        wr_en;
  logic [15:0] wr_val;
  logic [15:0] wr_time;
  logic        adv;
  logic        win_valid;
  logic [19:0] M1, M2, M3, P1, P2, P3;
  logic [4:0]  win_idx;
  logic [3:0]  level;
  logic        full;
  logic        overflow;

  extrema_window_reader dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .start     (start),
    .wr_en     (wr_en),
    .wr_val    (wr_val),
    .wr_time   (wr_time),
    .adv       (adv),
    .win_valid (win_valid),
    .M1        (M1),
    .M2        (M2),
    .M3        (M3),
    .P1        (P1),
    .P2        (P2),
    .P3        (P3),
    .win_idx   (win_idx),
    .level     (level),
    .full      (full),
    .overflow  (overflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        st;
    logic        we;
    logic        ad;
    ext_pair_t   pair;
    logic        e_valid;
    logic [3:0]  e_level;
    logic        e_full;
    logic        e_ov;
    logic [4:0]  e_idx;
    logic        chk_win;
    logic [19:0] e_p1, e_p2, e_p3, e_m1, e_m2, e_m3;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input bit st, input bit we, input bit ad, input int v, input int t,
                     input bit ev, input int el, input bit ef, input bit eo, input int ei);
    vec_t r;
    r.st = st; r.we = we; r.ad = ad;
    r.pair.value = 16'(v); r.pair.position = 16'(t);
    r.e_valid = ev; r.e_level = 4'(el); r.e_full = ef; r.e_ov = eo; r.e_idx = 5'(ei);
    r.chk_win = 1'b0;
    r.e_p1 = '0; r.e_p2 = '0; r.e_p3 = '0; r.e_m1 = '0; r.e_m2 = '0; r.e_m3 = '0;
    vecs.push_back(r);
  endtask

  task automatic win(input int p1, input int p2, input int p3,
                     input int m1, input int m2, input int m3);
    int k;
    k = vecs.size() - 1;
    vecs[k].chk_win = 1'b1;
    vecs[k].e_p1 = 20'(p1); vecs[k].e_p2 = 20'(p2); vecs[k].e_p3 = 20'(p3);
    vecs[k].e_m1 = 20'(m1); vecs[k].e_m2 = 20'(m2); vecs[k].e_m3 = 20'(m3);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".win_valid"}, 32'(win_valid), 32'd0);
    check({tag, ".level"},     32'(level),     32'd0);
    check({tag, ".full"},      32'(full),      32'd0);
    check({tag, ".overflow"},  32'(overflow),  32'd0);
    check({tag, ".win_idx"},   32'(win_idx),   32'd0);
    check({tag, ".M1"}, 32'(M1), 32'd0);
    check({tag, ".M2"}, 32'(M2), 32'd0);
    check({tag, ".M3"}, 32'(M3), 32'd0);
    check({tag, ".P1"}, 32'(P1), 32'd0);
    check({tag, ".P2"}, 32'(P2), 32'd0);
    check({tag, ".P3"}, 32'(P3), 32'd0);
  endtask

  task automatic drive(input bit st, input bit we, input bit ad, input int v, input int t);
    start = st; wr_en = we; adv = ad; wr_val = 16'(v); wr_time = 16'(t);
  endtask

  initial begin
    int cycles;
    RSTn = 1'b0;
    drive(0, 0, 0, 0, 0);

    // Fill, advance, drain back to FILL, ignored adv, refill.
    add(0,1,0,100,5,          0,1,0,0,0);
    add(0,1,0,'hFFCE,12,      0,2,0,0,0);
    add(0,1,0,80,20,          1,3,0,0,0); win(5,12,20,'h00064,'hFFFCE,'h00050);
    add(0,1,0,'hFFF9,31,      1,4,0,0,0); win(5,12,20,'h00064,'hFFFCE,'h00050);
    add(0,0,1,0,0,            1,3,0,0,1); win(12,20,31,'hFFFCE,'h00050,'hFFFF9);
    add(0,0,1,0,0,            0,2,0,0,2);
    add(0,0,1,0,0,            0,2,0,0,2);
    add(0,1,0,9,40,           1,3,0,0,2); win(20,31,40,'h00050,'hFFFF9,'h00009);
    add(1,0,0,0,0,            0,0,0,0,0); win(0,0,0,0,0,0);
    // Fill to full, overflow, push+pop while full.
    for (int i = 0; i < 8; i++) begin
      add(0,1,0,i,100+i,      i >= 2, i+1, i == 7, 0, 0);
      if (i >= 2) win(100,101,102,0,1,2);
    end
    add(0,1,0,'hFFFF,200,     1,8,1,1,0); win(100,101,102,0,1,2);
    add(0,1,1,5,201,          1,8,1,1,1); win(101,102,103,1,2,3);
    // Drain across the ring wrap point.
    for (int k = 0; k < 5; k++) begin
      add(0,0,1,0,0,          1,7-k,0,1,2+k);
      win(102+k, 103+k, (k == 4) ? 201 : 104+k, 2+k, 3+k, (k == 4) ? 5 : 4+k);
    end
    // start wins over simultaneous push and adv.
    add(1,1,1,1,1,            0,0,0,0,0); win(0,0,0,0,0,0);
    // Extension extremes.
    add(0,1,1,'h8000,7,       0,1,0,0,0);
    add(0,1,0,'h7FFF,'hFFFF,  0,2,0,0,0);
    add(0,1,0,0,3,            1,3,0,0,0); win(7,'hFFFF,3,'hF8000,'h07FFF,'h00000);

    repeat (2) @(posedge CLK);
    #1 check_all_zero("reset");
    @(negedge CLK);
    RSTn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      drive(vecs[i].st, vecs[i].we, vecs[i].ad,
            int'(vecs[i].pair.value), int'(vecs[i].pair.position));
      @(posedge CLK);
      #1;
      check($sformatf("v%0d.win_valid", i), 32'(win_valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d.level", i),     32'(level),     32'(vecs[i].e_level));
      check($sformatf("v%0d.full", i),      32'(full),      32'(vecs[i].e_full));
      check($sformatf("v%0d.overflow", i),  32'(overflow),  32'(vecs[i].e_ov));
      check($sformatf("v%0d.win_idx", i),   32'(win_idx),   32'(vecs[i].e_idx));
      if (vecs[i].chk_win) begin
        check($sformatf("v%0d.P1", i), 32'(P1), 32'(vecs[i].e_p1));
        check($sformatf("v%0d.P2", i), 32'(P2), 32'(vecs[i].e_p2));
        check($sformatf("v%0d.P3", i), 32'(P3), 32'(vecs[i].e_p3));
        check($sformatf("v%0d.M1", i), 32'(M1), 32'(vecs[i].e_m1));
        check($sformatf("v%0d.M2", i), 32'(M2), 32'(vecs[i].e_m2));
        check($sformatf("v%0d.M3", i), 32'(M3), 32'(vecs[i].e_m3));
      end
      $display("vec %0d: st=%0b we=%0b adv=%0b valid=%0b level=%0d idx=%0d ov=%0b P=%0d,%0d,%0d",
               i, vecs[i].st, vecs[i].we, vecs[i].ad, win_valid, level, win_idx, overflow,
               P1, P2, P3);
    end

    // Asynchronous reset mid-cycle with a valid window present.
    @(negedge CLK);
    drive(0, 0, 0, 0, 0);
    #2 RSTn = 1'b0;
    #1 check_all_zero("async_rst");
    $display("async reset: valid=%0b level=%0d", win_valid, level);
    @(negedge CLK);
    RSTn = 1'b1;

    // Window latency: valid exactly one edge after the third push.
    @(negedge CLK); drive(0, 1, 0, 1, 50);
    @(negedge CLK); drive(0, 1, 0, 2, 60);
    @(negedge CLK); drive(0, 1, 0, 3, 70);
    check("lat.pre_valid", 32'(win_valid), 32'd0);
    cycles = 0;
    while (!win_valid && cycles < 4) begin
      @(posedge CLK);
      #1 cycles++;
    end
    check("lat.cycles", 32'(cycles), 32'd1);
    check("lat.P1", 32'(P1), 32'd50);
    check("lat.P3", 32'(P3), 32'd70);
    $display("latency: valid after %0d cycle(s), P=%0d,%0d,%0d", cycles, P1, P2, P3);
    @(negedge CLK);
    drive(0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_extrema_window_reader

// File: doc/extrema_window_reader.md
Name: extrema_window_reader

Overview:
- Read side of the extremum store feeding the cubic-spline interpolator.
- Buffers (position, value) extremum pairs pushed by the extremum detector into a ring buffer.
- Presents a sliding 3-point window (M1..M3 values, P1..P3 positions) to the interpolator, and advances one point per segment-done pulse.
- Decouples burst extremum detection from the slower per-segment spline evaluation.

Parameters:
- DEPTH, 8, ring-buffer entries; power of two, at least 4.
- AW, 3, pointer width, log2(DEPTH).
- DW, 16, sample value and position width.
- OW, 20, width of the M/P window outputs.

Ports:
- CLK  in  1  system clock, rising edge.
- RSTn  in  1  asynchronous active-low reset.
- start  in  1  synchronous clear; same effect as reset, takes one cycle.
- wr_en  in  1  extremum flag; push one pair this cycle.
- wr_val  in  DW  extremum value, signed two's complement.
- wr_time  in  DW  extremum position (sample counter).
- adv  in  1  segment-done pulse from the interpolator; drop the oldest point.
- win_valid  out  1  M1..M3 and P1..P3 hold a valid window.
- M1, M2, M3  out  OW each  window values, oldest to newest, sign-extended.
- P1, P2, P3  out  OW each  window positions, oldest to newest, zero-extended.
- win_idx  out  5  segments served since clear, wraps at 31 to 0.
- level  out  AW+1  entries currently stored.
- full  out  1  level equals DEPTH.
- overflow  out  1  sticky; a push was lost.

Behaviour:
- Reset or start: pointers, level and win_idx go to 0. win_valid, full and overflow go to 0. All M and P outputs go to 0. No stored data survives.
- Push, no pop: wr_en with level < DEPTH writes at wr_ptr, increments wr_ptr (mod DEPTH) and increments level.
- Push when full, no pop: the write is dropped; overflow is set and held until reset or start.
- Pop: adv while win_valid increments rd_ptr (mod DEPTH), decrements level and increments win_idx.
- adv while win_valid is 0 is ignored; there is no state change.
- Push and pop in the same cycle: both are performed and level is unchanged. This also holds when full, with no overflow.
- Window registers load from entries rd_ptr, rd_ptr+1 and rd_ptr+2 (mod DEPTH), using the post-update pointer and level.
- States:
  - FILL: win_valid=0. Go to VALID when the next-cycle level is at least 3.
  - VALID: win_valid=1 and outputs are held stable. On a pop, if the new level is at least 3, reload the window and stay in VALID. Otherwise go to FILL.
- Latency:
  - The window becomes valid on the cycle after the push that makes level reach 3.
  - After adv, the advanced window (or win_valid=0) appears on the next cycle.
- Outputs in FILL keep their last window contents and must be ignored.
- Value extension: M = {{(OW-DW){wr_val[DW-1]}}, wr_val}. Position extension: P = {{(OW-DW){1'b0}}, wr_time}.
- Positions are stored raw with no monotonicity check. Wrap-around of the sample counter is the interpolator's concern.
- RSTn asserted mid-operation clears immediately, asynchronously. start asserted together with wr_en or adv: start wins and the push or pop is discarded.

Decomposition:
- Shared package holds:
  - DW and OW constants.
  - The extremum pair typedef: value [DW-1:0] and time [DW-1:0].
  - FSM state encoding: FILL=0, VALID=1.
- One natural sub-module, extrema_ring. It is a DEPTH-entry register array with one write port, three combinational read taps at rd_ptr+0/1/2, and level/full logic.
- The top level holds the FSM, the window output registers, win_idx and overflow.

Test Plan:
- Reset: assert RSTn low mid-run. Expect all outputs 0, win_valid=0, level=0, overflow=0 immediately, without waiting for CLK.
- Fill:
  - Push (t=5,v=100), then (12,-50), then (20,80) on consecutive cycles.
  - Expect win_valid=1 one cycle after the third push.
  - Expect M1=0x00064, M2=0xFFFCE, M3=0x00050; P1=5, P2=12, P3=20; win_idx=0.
- Advance: push (31,-7), then pulse adv. Next cycle expect P1..P3=12,20,31, M3=0xFFFF9, win_idx=1, level=3.
- Drain to FILL:
  - With level=3, pulse adv. Expect win_valid=0 next cycle and level=2.
  - Push (40,9). Expect win_valid=1 next cycle with P1..P3=20,31,40.
- Full and overflow:
  - Push 8 pairs with no adv. Expect full=1.
  - Push a 9th pair. Expect it dropped, overflow=1, level=8.
  - Then push and adv in the same cycle. Expect it accepted, level=8, overflow still 1.
  - Pulse start. Expect overflow=0, level=0.
- Ignored adv: pulse adv with level=2 and win_valid=0. Expect rd_ptr, level and win_idx unchanged.
